// File: rtl/marker_overlay.sv
// Draws a square outline marker centred on the tracked position onto an RGB pixel stream.
// The marker position is latched at start of frame, so a frame is never drawn with two positions.
module marker_overlay #(
  parameter int INPUT_WIDTH = 11,
  parameter int COLOR_WIDTH = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BOX_HALF    = 8,
  parameter int LINE_W      = 2,
  parameter logic [COLOR_WIDTH-1:0] MARK_R = '1,
  parameter logic [COLOR_WIDTH-1:0] MARK_G = '0,
  parameter logic [COLOR_WIDTH-1:0] MARK_B = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [26:0]            x_position,
  input  logic [26:0]            y_position,
  input  logic                   valid_position,
  input  logic                   enable,
  input  logic                   sof,
  input  logic                   pixel_valid,
  input  logic [COLOR_WIDTH-1:0] red_in,
  input  logic [COLOR_WIDTH-1:0] green_in,
  input  logic [COLOR_WIDTH-1:0] blue_in,
  output logic                   pixel_valid_out,
  output logic [COLOR_WIDTH-1:0] red_out,
  output logic [COLOR_WIDTH-1:0] green_out,
  output logic [COLOR_WIDTH-1:0] blue_out,
  output logic                   marker_active
);
  localparam int W  = INPUT_WIDTH;
  localparam int CW = COLOR_WIDTH;
  localparam logic [W-1:0]  H_MAX   = W'(H_ACTIVE - 1);
  localparam logic [W-1:0]  V_MAX   = W'(V_ACTIVE - 1);
  localparam logic [26:0]   H_MAX_P = 27'(H_ACTIVE - 1);
  localparam logic [26:0]   V_MAX_P = 27'(V_ACTIVE - 1);
  localparam logic [W:0]    HALF    = (W+1)'(BOX_HALF);
  localparam logic [W:0]    INNER   = (W+1)'(BOX_HALF - LINE_W);

  logic [W-1:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [W-1:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [W-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;
  logic          have_pending_q, have_pending_d;
  logic          marker_active_q, marker_active_d;
  logic          s1_valid_q, s1_valid_d, s1_draw_q, s1_draw_d;
  logic [CW-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic [W:0]    s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

  logic          sof_pix, hit;
  logic [W-1:0]  cur_x, cur_y, eff_ax, eff_ay;
  logic [W:0]    diff_x, diff_y;

  assign sof_pix = sof & pixel_valid;

  // Front end: raster position, position capture and frame-boundary apply.
  always_comb begin
    cur_x           = sof_pix ? '0 : x_cnt_q;
    cur_y           = sof_pix ? '0 : y_cnt_q;
    x_cnt_d         = x_cnt_q;
    y_cnt_d         = y_cnt_q;
    pend_x_d        = pend_x_q;
    pend_y_d        = pend_y_q;
    have_pending_d  = have_pending_q;
    act_x_d         = act_x_q;
    act_y_d         = act_y_q;
    marker_active_d = marker_active_q;
    if (pixel_valid) begin
      if (cur_x == H_MAX) begin
        x_cnt_d = '0;
        y_cnt_d = (cur_y == V_MAX) ? '0 : cur_y + 1'b1;
      end else begin
        x_cnt_d = cur_x + 1'b1;
        y_cnt_d = cur_y;
      end
    end
    if (valid_position) begin
      pend_x_d       = (x_position > H_MAX_P) ? H_MAX : x_position[W-1:0];
      pend_y_d       = (y_position > V_MAX_P) ? V_MAX : y_position[W-1:0];
      have_pending_d = 1'b1;
    end
    if (sof_pix) begin
      act_x_d         = pend_x_q;
      act_y_d         = pend_y_q;
      marker_active_d = have_pending_q;
    end
    // The sof pixel itself already belongs to the frame using the newly applied position.
    eff_ax = sof_pix ? pend_x_q : act_x_q;
    eff_ay = sof_pix ? pend_y_q : act_y_q;
    diff_x = {1'b0, cur_x} - {1'b0, eff_ax};
    diff_y = {1'b0, cur_y} - {1'b0, eff_ay};
    s1_dx_d    = diff_x[W] ? (~diff_x + 1'b1) : diff_x;
    s1_dy_d    = diff_y[W] ? (~diff_y + 1'b1) : diff_y;
    s1_draw_d  = (sof_pix ? have_pending_q : marker_active_q) & enable;
    s1_valid_d = pixel_valid;
    s1_r_d     = red_in;
    s1_g_d     = green_in;
    s1_b_d     = blue_in;
  end

  always_comb begin
    hit = s1_draw_q && (s1_dx_q <= HALF) && (s1_dy_q <= HALF) &&
          ((s1_dx_q > INNER) || (s1_dy_q > INNER));
    out_valid_d = s1_valid_q;
    out_r_d     = hit ? MARK_R : s1_r_q;
    out_g_d     = hit ? MARK_G : s1_g_q;
    out_b_d     = hit ? MARK_B : s1_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt_q         <= '0;
      y_cnt_q         <= '0;
      pend_x_q        <= '0;
      pend_y_q        <= '0;
      act_x_q         <= '0;
      act_y_q         <= '0;
      have_pending_q  <= 1'b0;
      marker_active_q <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_draw_q       <= 1'b0;
      s1_r_q          <= '0;
      s1_g_q          <= '0;
      s1_b_q          <= '0;
      s1_dx_q         <= '0;
      s1_dy_q         <= '0;
      out_valid_q     <= 1'b0;
      out_r_q         <= '0;
      out_g_q         <= '0;
      out_b_q         <= '0;
    end else begin
      x_cnt_q         <= x_cnt_d;
      y_cnt_q         <= y_cnt_d;
      pend_x_q        <= pend_x_d;
      pend_y_q        <= pend_y_d;
      act_x_q         <= act_x_d;
      act_y_q         <= act_y_d;
      have_pending_q  <= have_pending_d;
      marker_active_q <= marker_active_d;
      s1_valid_q      <= s1_valid_d;
      s1_draw_q       <= s1_draw_d;
      s1_r_q          <= s1_r_d;
      s1_g_q          <= s1_g_d;
      s1_b_q          <= s1_b_d;
      s1_dx_q         <= s1_dx_d;
      s1_dy_q         <= s1_dy_d;
      out_valid_q     <= out_valid_d;
      out_r_q         <= out_r_d;
      out_g_q         <= out_g_d;
      out_b_q         <= out_b_d;
    end
  end

  assign pixel_valid_out = out_valid_q;
  assign red_out         = out_r_q;
  assign green_out       = out_g_q;
  assign blue_out        = out_b_q;
  assign marker_active   = marker_active_q;
endmodule

// File: tb/tb_marker_overlay.sv
// Directed bench for marker_overlay on a reduced 128x64 raster so whole frames stay short.
module tb_marker_overlay;
  localparam int H = 128;
  localparam int V = 64;
  localparam logic [29:0] MARK    = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] NOTSEEN = '1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [26:0] x_position = '0, y_position = '0;
  logic        valid_position = 1'b0, enable = 1'b1, sof = 1'b0, pixel_valid = 1'b0;
  logic [9:0]  red_in = '0, green_in = '0, blue_in = '0;
  logic        pixel_valid_out, marker_active;
  logic [9:0]  red_out, green_out, blue_out;

  int checks = 0;
  int failures = 0;
  int out_cnt, orphan;
  bit ma_seen;
  int bx = 0, by = 0;
  int tag_q[$];
  logic [29:0] out_mem [0:H*V-1];

  marker_overlay #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset),
    .x_position(x_position), .y_position(y_position), .valid_position(valid_position),
    .enable(enable), .sof(sof), .pixel_valid(pixel_valid),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pixel_valid_out(pixel_valid_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .marker_active(marker_active)
  );

  always #5 clk = ~clk;

  // Output capture: each output pixel is filed under the raster position it was sent at.
  always @(negedge clk) begin
    if (marker_active) ma_seen = 1'b1;
    if (pixel_valid_out) begin
      if (tag_q.size() > 0) begin
        out_mem[tag_q.pop_front()] = {red_out, green_out, blue_out};
        out_cnt++;
      end else begin
        orphan++;
      end
    end
  end

  function automatic logic [29:0] pix_color(input int x, input int y);
    if (x == 120 && y == 60) return {10'h155, 10'h0AA, 10'h3FF};
    return {10'(x), 10'(y) | 10'h200, 10'h155};
  endfunction

  task automatic drive_cycle(input bit s, input bit v, input bit vp, input int px, input int py);
    if (s && v) begin bx = 0; by = 0; end
    sof = s;
    pixel_valid = v;
    {red_in, green_in, blue_in} = v ? pix_color(bx, by) : 30'h0;
    valid_position = vp;
    x_position = 27'(px);
    y_position = 27'(py);
    if (v) begin
      tag_q.push_back(by * H + bx);
      bx++;
      if (bx == H) begin bx = 0; by = (by == V - 1) ? 0 : by + 1; end
    end
    @(posedge clk); #1;
    sof = 1'b0; pixel_valid = 1'b0; valid_position = 1'b0;
  endtask

  task automatic stream(input int n, input bit with_sof);
    for (int i = 0; i < n; i++) drive_cycle(with_sof && i == 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_obs();
    out_cnt = 0; orphan = 0; ma_seen = 1'b0;
    for (int i = 0; i < H * V; i++) out_mem[i] = NOTSEEN;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pixel_valid_out !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", pixel_valid_out); end
    checks++; if (red_out !== 10'h0) begin failures++; $display("FAIL reset_red got=%h exp=0", red_out); end
    checks++; if (green_out !== 10'h0) begin failures++; $display("FAIL reset_green got=%h exp=0", green_out); end
    checks++; if (blue_out !== 10'h0) begin failures++; $display("FAIL reset_blue got=%h exp=0", blue_out); end
    checks++; if (marker_active !== 1'b0) begin failures++; $display("FAIL reset_marker_active got=%b exp=0", marker_active); end
    reset = 1'b0;
  endtask

  task automatic test_no_position();
    logic [29:0] got;
    clear_obs();
    stream(H * V, 1'b1);
    flush();
    got = out_mem[60 * H + 120];
    checks++; if (got !== {10'h155, 10'h0AA, 10'h3FF}) begin failures++; $display("FAIL nopos_pixel got=%h exp=%h", got, {10'h155, 10'h0AA, 10'h3FF}); end
    got = out_mem[0];
    checks++; if (got !== pix_color(0, 0)) begin failures++; $display("FAIL nopos_origin got=%h exp=%h", got, pix_color(0, 0)); end
    checks++; if (ma_seen !== 1'b0) begin failures++; $display("FAIL nopos_marker_active got=%b exp=0", ma_seen); end
    checks++; if (out_cnt != H * V) begin failures++; $display("FAIL nopos_count got=%0d exp=%0d", out_cnt, H * V); end
    checks++; if (orphan != 0) begin failures++; $display("FAIL nopos_orphan got=%0d exp=0", orphan); end
  endtask

  task automatic test_capture();
    int xs[7] = '{92, 93, 94, 100, 109, 100, 108};
    int ys[7] = '{50, 50, 50, 50, 50, 42, 58};
    bit mk[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [29:0] got, exp;
    clear_obs();
    stream(1000, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1, 100, 50);
    stream(H * V - 1000, 1'b0);
    flush();
    for (int i = 0; i < 7; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL capture_same_frame (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
    checks++; if (ma_seen !== 1'b0) begin failures++; $display("FAIL capture_ma_early got=%b exp=0", ma_seen); end
    clear_obs();
    stream(59 * H, 1'b1);
    flush();
    for (int i = 0; i < 7; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = mk[i] ? MARK : pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL capture_next_frame (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
    checks++; if (marker_active !== 1'b1) begin failures++; $display("FAIL capture_marker_active got=%b exp=1", marker_active); end
  endtask

  task automatic test_simultaneous();
    int xs[4] = '{92, 12, 20, 20};
    int ys[4] = '{50, 20, 12, 20};
    bit mk_a[4] = '{1, 0, 0, 0};
    bit mk_b[4] = '{0, 1, 1, 0};
    logic [29:0] got, exp;
    clear_obs();
    drive_cycle(1'b1, 1'b1, 1'b1, 20, 20);
    stream(59 * H - 1, 1'b0);
    flush();
    for (int i = 0; i < 4; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = mk_a[i] ? MARK : pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL simul_frame_a (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
    clear_obs();
    stream(51 * H, 1'b1);
    flush();
    for (int i = 0; i < 4; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = mk_b[i] ? MARK : pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL simul_frame_b (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
  endtask

  task automatic test_saturation();
    int xs[10] = '{119, 127, 127, 118, 120, 0, 1, 127, 127, 0};
    int ys[10] = '{63, 55, 63, 63, 63, 63, 63, 0, 1, 0};
    bit mk[10] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [29:0] got, exp;
    drive_cycle(1'b0, 1'b0, 1'b1, 1000, 900);
    clear_obs();
    stream(H * V, 1'b1);
    flush();
    for (int i = 0; i < 10; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = mk[i] ? MARK : pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL saturation (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
  endtask

  task automatic test_bubbles();
    bit pat[9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    int xs[7] = '{12, 11, 10, 4, 0, 0, 4};
    int ys[7] = '{2, 2, 2, 10, 0, 10, 2};
    bit mk[7] = '{1, 1, 0, 1, 0, 1, 0};
    bit prev;
    int sent, cyc;
    logic [29:0] got, exp;
    drive_cycle(1'b0, 1'b0, 1'b1, 4, 2);
    clear_obs();
    prev = 1'b0;
    sent = 0;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(i == 0, pat[i], 1'b0, 0, 0);
      if (pat[i]) sent++;
      checks++; if (pixel_valid_out !== prev) begin failures++; $display("FAIL bubble_pattern cycle=%0d got=%b exp=%b", i, pixel_valid_out, prev); end
      prev = pat[i];
    end
    cyc = 0;
    while (sent < 11 * H) begin
      if (cyc % 3 == 2) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
      else begin drive_cycle(1'b0, 1'b1, 1'b0, 0, 0); sent++; end
      cyc++;
    end
    flush();
    checks++; if (out_cnt != 11 * H) begin failures++; $display("FAIL bubble_count got=%0d exp=%0d", out_cnt, 11 * H); end
    checks++; if (orphan != 0) begin failures++; $display("FAIL bubble_orphan got=%0d exp=0", orphan); end
    for (int i = 0; i < 7; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = mk[i] ? MARK : pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL bubble_marks (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] got, exp;
    clear_obs();
    stream(5 * H, 1'b1);
    reset = 1'b1;
    pixel_valid = 1'b1;
    {red_in, green_in, blue_in} = pix_color(5, 5);
    @(posedge clk); #1;
    tag_q.delete();
    bx = 0; by = 0;
    checks++; if (pixel_valid_out !== 1'b0) begin failures++; $display("FAIL midreset_pv got=%b exp=0", pixel_valid_out); end
    checks++; if ({red_out, green_out, blue_out} !== 30'h0) begin failures++; $display("FAIL midreset_rgb got=%h exp=0", {red_out, green_out, blue_out}); end
    checks++; if (marker_active !== 1'b0) begin failures++; $display("FAIL midreset_marker_active got=%b exp=0", marker_active); end
    reset = 1'b0;
    pixel_valid = 1'b0;
    clear_obs();
    stream(11 * H, 1'b1);
    flush();
    got = out_mem[2 * H + 12]; exp = pix_color(12, 2);
    checks++; if (got !== exp) begin failures++; $display("FAIL midreset_after_12_2 got=%h exp=%h", got, exp); end
    got = out_mem[10 * H + 4]; exp = pix_color(4, 10);
    checks++; if (got !== exp) begin failures++; $display("FAIL midreset_after_4_10 got=%h exp=%h", got, exp); end
    checks++; if (ma_seen !== 1'b0) begin failures++; $display("FAIL midreset_ma_seen got=%b exp=0", ma_seen); end
    drive_cycle(1'b0, 1'b0, 1'b1, 4, 2);
    clear_obs();
    stream(3 * H, 1'b1);
    flush();
    got = out_mem[2 * H + 12];
    checks++; if (got !== MARK) begin failures++; $display("FAIL midreset_reload_12_2 got=%h exp=%h", got, MARK); end
    checks++; if (marker_active !== 1'b1) begin failures++; $display("FAIL midreset_reload_ma got=%b exp=1", marker_active); end
  endtask

  task automatic test_enable_off();
    int xs[4] = '{12, 11, 4, 0};
    int ys[4] = '{2, 2, 10, 10};
    logic [29:0] got, exp;
    enable = 1'b0;
    clear_obs();
    stream(11 * H, 1'b1);
    flush();
    for (int i = 0; i < 4; i++) begin
      got = out_mem[ys[i] * H + xs[i]];
      exp = pix_color(xs[i], ys[i]);
      checks++; if (got !== exp) begin failures++; $display("FAIL enable_off (%0d,%0d) got=%h exp=%h", xs[i], ys[i], got, exp); end
    end
    checks++; if (marker_active !== 1'b1) begin failures++; $display("FAIL enable_off_ma got=%b exp=1", marker_active); end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_no_position();
    test_capture();
    test_simultaneous();
    test_saturation();
    test_bubbles();
    test_reset_mid();
    test_enable_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
